// File: rtl/key_debounce_repeat_if.sv
// Key conditioning bus: raw key in, debounced level and single-cycle events out.
interface key_debounce_repeat_if;
    logic i_key;
    logic o_level;
    logic o_press;
    logic o_release;
    logic o_tick;

    modport master (
        output i_key,
        input  o_level,
        input  o_press,
        input  o_release,
        input  o_tick
    );

    modport slave (
        input  i_key,
        output o_level,
        output o_press,
        output o_release,
        output o_tick
    );
endinterface

// File: rtl/key_debounce_repeat.sv
// Push-button conditioner: 2-FF sync, stable-count debounce, press/release
// pulses and an auto-repeat tick generator while the key stays held.
module key_debounce_repeat #(
    parameter int ACTIVE_LOW = 1,
    parameter int DB_CYCLES  = 1_000_000,
    parameter int REP_DELAY  = 25_000_000,
    parameter int REP_PERIOD = 5_000_000
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    key_debounce_repeat_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } rep_state_t;

    localparam logic IDLE_LVL = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
    localparam int   DB_W     = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);
    localparam int   REP_MAX  = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
    localparam int   REP_W    = (REP_MAX > 1) ? $clog2(REP_MAX + 1) : 1;
    // REP_DELAY==0 never enters ST_DELAY, so its compare value is a don't-care.
    localparam logic [REP_W-1:0] DELAY_LAST  = REP_W'((REP_DELAY > 0) ? REP_DELAY - 1 : 0);
    localparam logic [REP_W-1:0] PERIOD_LAST = REP_W'((REP_PERIOD > 0) ? REP_PERIOD - 1 : 0);

    logic              sync1_r;
    logic              sync2_r;
    logic              key_s;
    logic [DB_W-1:0]   db_cnt_r;
    logic              level_r;
    logic              press_r;
    logic              release_r;
    logic              tick_r;
    logic              db_hit_s;
    logic              press_s;
    logic              rel_s;
    rep_state_t        state_r;
    rep_state_t        state_nx_s;
    logic [REP_W-1:0]  rep_cnt_r;
    logic [REP_W-1:0]  rep_cnt_nx_s;
    logic              tick_nx_s;

    assign key_s    = sync2_r ^ IDLE_LVL;
    assign db_hit_s = (key_s != level_r) && (db_cnt_r == DB_LAST);
    assign press_s  = db_hit_s & key_s;
    assign rel_s    = db_hit_s & ~key_s;

    // Two-stage synchroniser for the asynchronous key pin.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync1_r <= IDLE_LVL;
            sync2_r <= IDLE_LVL;
        end else begin
            sync1_r <= bus.i_key;
            sync2_r <= sync1_r;
        end
    end

    // Debounce: a single cycle of agreement restarts the stability count.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            level_r   <= 1'b0;
            db_cnt_r  <= '0;
            press_r   <= 1'b0;
            release_r <= 1'b0;
        end else begin
            press_r   <= press_s;
            release_r <= rel_s;
            if (key_s == level_r) begin
                db_cnt_r <= '0;
            end else if (db_hit_s) begin
                level_r  <= key_s;
                db_cnt_r <= '0;
            end else begin
                db_cnt_r <= db_cnt_r + DB_W'(1);
            end
        end
    end

    // Repeat FSM state and counter registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r   <= ST_IDLE;
            rep_cnt_r <= '0;
            tick_r    <= 1'b0;
        end else begin
            state_r   <= state_nx_s;
            rep_cnt_r <= rep_cnt_nx_s;
            tick_r    <= tick_nx_s;
        end
    end

    // Repeat FSM next state; a release in the same cycle as an expiry suppresses the tick.
    always_comb begin
        state_nx_s   = state_r;
        rep_cnt_nx_s = rep_cnt_r;
        tick_nx_s    = 1'b0;
        if (rel_s) begin
            state_nx_s   = ST_IDLE;
            rep_cnt_nx_s = '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    rep_cnt_nx_s = '0;
                    if (press_s) begin
                        tick_nx_s  = 1'b1;
                        state_nx_s = (REP_DELAY > 0) ? ST_DELAY : ST_IDLE;
                    end else begin
                        state_nx_s = ST_IDLE;
                    end
                end
                ST_DELAY: begin
                    if (rep_cnt_r == DELAY_LAST) begin
                        tick_nx_s    = 1'b1;
                        rep_cnt_nx_s = '0;
                        state_nx_s   = ST_REPEAT;
                    end else begin
                        rep_cnt_nx_s = rep_cnt_r + REP_W'(1);
                    end
                end
                ST_REPEAT: begin
                    if (rep_cnt_r == PERIOD_LAST) begin
                        tick_nx_s    = 1'b1;
                        rep_cnt_nx_s = '0;
                    end else begin
                        rep_cnt_nx_s = rep_cnt_r + REP_W'(1);
                    end
                end
                default: begin
                    state_nx_s   = ST_IDLE;
                    rep_cnt_nx_s = '0;
                end
            endcase
        end
    end

    assign bus.o_level   = level_r;
    assign bus.o_press   = press_r;
    assign bus.o_release = release_r;
    assign bus.o_tick    = tick_r;

endmodule

// File: tb/tb_key_debounce_repeat.sv
// Directed bench for key_debounce_repeat (DB=4, delay=10, period=3) plus a
// REP_DELAY=0 instance sharing the same key and reset.
module tb_key_debounce_repeat;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic key = 1'b1;

    int n_vec = 0;
    int n_bad = 0;

    int press_seen = 0;
    int rel_seen   = 0;
    int tick_seen  = 0;
    int tick0_seen = 0;
    int viol_seen  = 0;

    key_debounce_repeat_if kb ();
    key_debounce_repeat_if kb0 ();

    assign kb.i_key  = key;
    assign kb0.i_key = key;

    key_debounce_repeat #(
        .ACTIVE_LOW (1),
        .DB_CYCLES  (4),
        .REP_DELAY  (10),
        .REP_PERIOD (3)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (kb)
    );

    key_debounce_repeat #(
        .ACTIVE_LOW (1),
        .DB_CYCLES  (4),
        .REP_DELAY  (0),
        .REP_PERIOD (3)
    ) dut0 (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (kb0)
    );

    always #5 clk = ~clk;

    // Pulse counters and the tick-implies-level invariant, sampled mid-cycle.
    always @(negedge clk) begin
        if (kb.o_press)               press_seen++;
        if (kb.o_release)             rel_seen++;
        if (kb.o_tick)                tick_seen++;
        if (kb0.o_tick)               tick0_seen++;
        if (kb.o_tick && !kb.o_level) viol_seen++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required normal completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; inputs driven here are sampled by the following edge.
    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int p0, t0, t00, r0;
        logic exp_tick;

        // 1: reset with key released
        key = 1'b1;
        rst = 1'b1;
        cyc(3);
        check("rst_level", 32'(kb.o_level), 32'd0);
        check("rst_press", 32'(kb.o_press), 32'd0);
        check("rst_rel",   32'(kb.o_release), 32'd0);
        check("rst_tick",  32'(kb.o_tick), 32'd0);
        rst = 1'b0;
        p0 = press_seen; t0 = tick_seen; r0 = rel_seen;
        cyc(50);
        check("idle_press_cnt", 32'(press_seen - p0), 32'd0);
        check("idle_tick_cnt",  32'(tick_seen - t0), 32'd0);
        check("idle_rel_cnt",   32'(rel_seen - r0), 32'd0);
        check("idle_level",     32'(kb.o_level), 32'd0);

        // 2: clean press, events land 6 edges after the drive edge
        key = 1'b0;
        cyc(5);
        check("press_early_level", 32'(kb.o_level), 32'd0);
        check("press_early_press", 32'(kb.o_press), 32'd0);
        cyc(1);
        check("press_level", 32'(kb.o_level), 32'd1);
        check("press_press", 32'(kb.o_press), 32'd1);
        check("press_tick",  32'(kb.o_tick), 32'd1);
        cyc(1);
        check("press_pulse_end", 32'(kb.o_press), 32'd0);
        check("press_tick_end",  32'(kb.o_tick), 32'd0);
        check("press_level_hold", 32'(kb.o_level), 32'd1);
        key = 1'b1;
        cyc(6);
        check("quick_rel_pulse", 32'(kb.o_release), 32'd1);
        check("quick_rel_level", 32'(kb.o_level), 32'd0);
        cyc(10);

        // 3: bounce bursts shorter than the debounce window are rejected
        p0 = press_seen;
        key = 1'b0; cyc(3);
        key = 1'b1; cyc(1);
        key = 1'b0; cyc(3);
        key = 1'b1; cyc(12);
        check("bounce_press_cnt", 32'(press_seen - p0), 32'd0);
        check("bounce_level",     32'(kb.o_level), 32'd0);
        key = 1'b0; cyc(10);
        check("stable_press_cnt", 32'(press_seen - p0), 32'd1);
        key = 1'b1; cyc(15);
        check("stable_rel_level", 32'(kb.o_level), 32'd0);

        // 4: hold; ticks at P, P+10, P+13, ... with P = 6 edges after the drive
        p0 = press_seen; t00 = tick0_seen;
        key = 1'b0;
        for (int k = 1; k <= 34; k++) begin
            cyc(1);
            exp_tick = (k == 6) || (k >= 16 && ((k - 16) % 3) == 0);
            check($sformatf("hold_tick_k%0d", k), 32'(kb.o_tick), 32'(exp_tick));
            check($sformatf("hold_press_k%0d", k), 32'(kb.o_press), 32'(k == 6));
            check($sformatf("hold0_tick_k%0d", k), 32'(kb0.o_tick), 32'(k == 6));
        end
        check("hold_press_cnt", 32'(press_seen - p0), 32'd1);

        // 5: release timed so the repeat expiry coincides with the release pulse
        key = 1'b1;
        for (int j = 1; j <= 6; j++) begin
            cyc(1);
            exp_tick = (j < 6) && (((34 + j - 16) % 3) == 0);
            check($sformatf("rel_tick_j%0d", j), 32'(kb.o_tick), 32'(exp_tick));
            check($sformatf("rel_pulse_j%0d", j), 32'(kb.o_release), 32'(j == 6));
            check($sformatf("rel_level_j%0d", j), 32'(kb.o_level), 32'(j < 6));
        end
        t0 = tick_seen;
        cyc(20);
        check("after_rel_ticks", 32'(tick_seen - t0), 32'd0);
        check("delay0_tick_cnt", 32'(tick0_seen - t00), 32'd1);

        // 6: reset while in the repeat phase with the key still held
        key = 1'b0;
        cyc(20);
        check("pre_rst_level", 32'(kb.o_level), 32'd1);
        rst = 1'b1;
        for (int j = 1; j <= 3; j++) begin
            cyc(1);
            check($sformatf("midrst_level_%0d", j), 32'(kb.o_level), 32'd0);
            check($sformatf("midrst_tick_%0d", j),  32'(kb.o_tick), 32'd0);
            check($sformatf("midrst_press_%0d", j), 32'(kb.o_press), 32'd0);
        end
        rst = 1'b0;
        cyc(5);
        check("post_rst_early_press", 32'(kb.o_press), 32'd0);
        check("post_rst_early_level", 32'(kb.o_level), 32'd0);
        cyc(1);
        check("post_rst_press", 32'(kb.o_press), 32'd1);
        check("post_rst_tick",  32'(kb.o_tick), 32'd1);
        check("post_rst_level", 32'(kb.o_level), 32'd1);
        key = 1'b1;
        cyc(15);

        check("tick_without_level", 32'(viol_seen), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
